// File: rtl/pq_pkg.sv
// Shared types and helpers for the sorted-register priority queue.
package pq_pkg;

  // Keys are zero-extended to this width before comparison, so WIDTH
  // must not exceed it.
  localparam int PQ_KEY_MAX_W = 64;

  // Operation requested this cycle, decoded from loadIn/shiftOut.
  typedef enum logic [1:0] {
    PQ_IDLE = 2'd0,
    PQ_INS  = 2'd1,
    PQ_REM  = 2'd2,
    PQ_SWAP = 2'd3
  } pq_op_e;

  // Per-slot next-state source.
  //   SEL_PREV: take slot i-1 (entries move away from the top)
  //   SEL_NEXT: take slot i+1 (entries move toward the top)
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_NEW  = 2'd1,
    SEL_PREV = 2'd2,
    SEL_NEXT = 2'd3
  } pq_sel_e;

  function automatic pq_op_e decode_op(input logic load, input logic shift);
    pq_op_e op;
    case ({load, shift})
      2'b10:   op = PQ_INS;
      2'b01:   op = PQ_REM;
      2'b11:   op = PQ_SWAP;
      default: op = PQ_IDLE;
    endcase
    return op;
  endfunction

  // Strict "a ranks ahead of b"; unsigned comparison.
  function automatic logic better(input logic [PQ_KEY_MAX_W-1:0] a,
                                  input logic [PQ_KEY_MAX_W-1:0] b,
                                  input logic                    max_first);
    return max_first ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/pq_slot.sv
// One queue slot: key and valid registers with a four-way source mux.
module pq_slot
  import pq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             r,
  input  logic             clear,
  input  pq_sel_e          sel,
  input  logic [WIDTH-1:0] new_key,
  input  logic [WIDTH-1:0] prev_key,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] next_key,
  input  logic             next_valid,
  output logic [WIDTH-1:0] key,
  output logic             valid
);

  logic [WIDTH-1:0] key_reg, key_next;
  logic             valid_reg, valid_next;

  // Pick the slot's next contents from the selected source.
  always_comb begin
    key_next   = key_reg;
    valid_next = valid_reg;
    case (sel)
      SEL_NEW: begin
        key_next   = new_key;
        valid_next = 1'b1;
      end
      SEL_PREV: begin
        key_next   = prev_key;
        valid_next = prev_valid;
      end
      SEL_NEXT: begin
        key_next   = next_key;
        valid_next = next_valid;
      end
      default: ;
    endcase
  end

  // Slot state register; clear flushes to an empty, zeroed slot.
  always_ff @(posedge ck or negedge r) begin
    if (!r) begin
      key_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (clear) begin
      key_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      key_reg   <= key_next;
      valid_reg <= valid_next;
    end
  end

  assign key   = key_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/pri_queue_param.sv
// Parametrised sorted-register priority queue. Slots stay ordered best-first,
// so the best key is always in slot 0 and an insert only needs a compare
// vector and a one-hot-ish position decode.
module pri_queue_param
  import pq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_FIRST = 1
) (
  input  logic                       ck,
  input  logic                       r,
  input  logic                       clear,
  input  logic                       loadIn,
  input  logic                       shiftOut,
  input  logic [WIDTH-1:0]           newVal,
  output logic [WIDTH-1:0]           top,
  output logic                       topValid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] slot_key [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] beats;         // newVal strictly better than slot i
  logic [CW-1:0]    count_reg;
  logic             overflow_reg;
  logic             underflow_reg;
  logic [CW-1:0]    ins_pos;
  logic [CW-1:0]    swap_pos;
  logic             is_full, is_empty;
  logic             do_ins, do_rem, do_swap;
  pq_op_e           op;

  assign op       = decode_op(loadIn, shiftOut);
  assign is_full  = (count_reg == CW'(DEPTH));
  assign is_empty = (count_reg == '0);
  assign do_ins   = (op == PQ_INS)  && !is_full;
  assign do_rem   = (op == PQ_REM)  && !is_empty;
  // Swap on an empty queue is a pass-through: nothing is stored or flagged.
  assign do_swap  = (op == PQ_SWAP) && !is_empty;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      pq_sel_e          slot_sel;
      logic [WIDTH-1:0] prev_key, next_key;
      logic             prev_valid, next_valid;

      assign beats[gi] = slot_valid[gi] &&
                         better(PQ_KEY_MAX_W'(newVal), PQ_KEY_MAX_W'(slot_key[gi]),
                                (MAX_FIRST != 0));

      if (gi == 0) begin : g_first
        assign prev_key   = '0;
        assign prev_valid = 1'b0;
      end else begin : g_mid_prev
        assign prev_key   = slot_key[gi-1];
        assign prev_valid = slot_valid[gi-1];
      end

      if (gi == DEPTH-1) begin : g_last
        assign next_key   = '0;
        assign next_valid = 1'b0;
      end else begin : g_mid_next
        assign next_key   = slot_key[gi+1];
        assign next_valid = slot_valid[gi+1];
      end

      // Route this slot's source: insert opens a gap at ins_pos, remove
      // pulls everything up, swap pulls up only the entries ahead of the
      // new key's landing position (swap_pos-1).
      always_comb begin
        slot_sel = SEL_HOLD;
        if (do_ins) begin
          if (CW'(gi) == ins_pos)      slot_sel = SEL_NEW;
          else if (CW'(gi) > ins_pos)  slot_sel = SEL_PREV;
        end else if (do_rem) begin
          slot_sel = SEL_NEXT;
        end else if (do_swap) begin
          if (CW'(gi+1) == swap_pos)     slot_sel = SEL_NEW;
          else if (CW'(gi+1) < swap_pos) slot_sel = SEL_NEXT;
        end
      end

      pq_slot #(.WIDTH(WIDTH)) u_slot (
        .ck        (ck),
        .r         (r),
        .clear     (clear),
        .sel       (slot_sel),
        .new_key   (newVal),
        .prev_key  (prev_key),
        .prev_valid(prev_valid),
        .next_key  (next_key),
        .next_valid(next_valid),
        .key       (slot_key[gi]),
        .valid     (slot_valid[gi])
      );
    end
  endgenerate

  // Insertion position: first slot whose key is strictly worse than newVal,
  // else the first free slot. Ties therefore land behind existing equals.
  // For a swap slot 0 is being discarded, so only slots 1.. are searched.
  always_comb begin
    ins_pos  = count_reg;
    swap_pos = count_reg;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (beats[i]) ins_pos = CW'(i);
    end
    for (int i = DEPTH-1; i >= 1; i--) begin
      if (beats[i]) swap_pos = CW'(i);
    end
  end

  // Occupancy counter and sticky error flags.
  always_ff @(posedge ck or negedge r) begin
    if (!r) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clear) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (do_ins) count_reg <= count_reg + CW'(1);
      if (do_rem) count_reg <= count_reg - CW'(1);
      if ((op == PQ_INS) && is_full)  overflow_reg  <= 1'b1;
      if ((op == PQ_REM) && is_empty) underflow_reg <= 1'b1;
    end
  end

  assign top       = slot_key[0];
  assign topValid  = slot_valid[0];
  assign count     = count_reg;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_pri_queue_param.sv
// Self-checking bench: a max-first and a min-first queue share one stimulus
// stream and are compared against a sorted-array reference model each cycle.
module tb_pri_queue_param;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int CW = $clog2(D+1);

  logic          ck = 1'b0;
  logic          r;
  logic          clear, loadIn, shiftOut;
  logic [W-1:0]  newVal;

  logic [W-1:0]  top_mx, top_mn;
  logic          tv_mx, tv_mn, full_mx, full_mn, empty_mx, empty_mn;
  logic          ov_mx, ov_mn, un_mx, un_mn;
  logic [CW-1:0] cnt_mx, cnt_mn;

  always #5 ck = ~ck;

  pri_queue_param #(.WIDTH(W), .DEPTH(D), .MAX_FIRST(1)) u_max (
    .ck(ck), .r(r), .clear(clear), .loadIn(loadIn), .shiftOut(shiftOut),
    .newVal(newVal), .top(top_mx), .topValid(tv_mx), .count(cnt_mx),
    .full(full_mx), .empty(empty_mx), .overflow(ov_mx), .underflow(un_mx)
  );

  pri_queue_param #(.WIDTH(W), .DEPTH(D), .MAX_FIRST(0)) u_min (
    .ck(ck), .r(r), .clear(clear), .loadIn(loadIn), .shiftOut(shiftOut),
    .newVal(newVal), .top(top_mn), .topValid(tv_mn), .count(cnt_mn),
    .full(full_mn), .empty(empty_mn), .overflow(ov_mn), .underflow(un_mn)
  );

  // Reference model: index 0 = max-first, index 1 = min-first.
  int mq   [2][D];
  int mcnt [2];
  bit mov  [2];
  bit mun  [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic expect_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // True when key a ranks strictly behind key b in queue m.
  function automatic bit worse(input int m, input int a, input int b);
    return (m == 0) ? (a < b) : (a > b);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0;
      mov[m]  = 0;
      mun[m]  = 0;
    end
  endtask

  task automatic model_insert(input int m, input int v);
    int p;
    p = mcnt[m];
    for (int i = 0; i < mcnt[m]; i++) begin
      if (worse(m, mq[m][i], v)) begin
        p = i;
        break;
      end
    end
    for (int i = mcnt[m]; i > p; i--) mq[m][i] = mq[m][i-1];
    mq[m][p] = v;
    mcnt[m]++;
  endtask

  task automatic model_pop(input int m);
    for (int i = 0; i < mcnt[m]-1; i++) mq[m][i] = mq[m][i+1];
    mcnt[m]--;
  endtask

  task automatic model_step(input bit ld, input bit sh, input int v, input bit clr);
    for (int m = 0; m < 2; m++) begin
      if (clr) begin
        mcnt[m] = 0;
        mov[m]  = 0;
        mun[m]  = 0;
      end else if (ld && !sh) begin
        if (mcnt[m] == D) mov[m] = 1;
        else model_insert(m, v);
      end else if (sh && !ld) begin
        if (mcnt[m] == 0) mun[m] = 1;
        else model_pop(m);
      end else if (ld && sh) begin
        if (mcnt[m] > 0) begin
          model_pop(m);
          model_insert(m, v);
        end
      end
    end
  endtask

  task automatic check_outputs(input string ctx);
    for (int m = 0; m < 2; m++) begin
      string pfx;
      int exp_top;
      pfx = {ctx, (m == 0) ? ".max" : ".min"};
      exp_top = (mcnt[m] > 0) ? mq[m][0] : 0;
      if (m == 0) begin
        expect_eq({pfx, ".top"},   int'(top_mx),   exp_top);
        expect_eq({pfx, ".tv"},    int'(tv_mx),    int'(mcnt[m] > 0));
        expect_eq({pfx, ".count"}, int'(cnt_mx),   mcnt[m]);
        expect_eq({pfx, ".full"},  int'(full_mx),  int'(mcnt[m] == D));
        expect_eq({pfx, ".empty"}, int'(empty_mx), int'(mcnt[m] == 0));
        expect_eq({pfx, ".ovf"},   int'(ov_mx),    int'(mov[m]));
        expect_eq({pfx, ".unf"},   int'(un_mx),    int'(mun[m]));
      end else begin
        expect_eq({pfx, ".top"},   int'(top_mn),   exp_top);
        expect_eq({pfx, ".tv"},    int'(tv_mn),    int'(mcnt[m] > 0));
        expect_eq({pfx, ".count"}, int'(cnt_mn),   mcnt[m]);
        expect_eq({pfx, ".full"},  int'(full_mn),  int'(mcnt[m] == D));
        expect_eq({pfx, ".empty"}, int'(empty_mn), int'(mcnt[m] == 0));
        expect_eq({pfx, ".ovf"},   int'(ov_mn),    int'(mov[m]));
        expect_eq({pfx, ".unf"},   int'(un_mn),    int'(mun[m]));
      end
    end
  endtask

  // One clocked transaction; inputs are driven 1 ns after an edge and
  // outputs sampled 1 ns after the next one.
  task automatic do_op(input string ctx, input bit ld, input bit sh,
                       input int v, input bit clr);
    loadIn   = ld;
    shiftOut = sh;
    newVal   = W'(v);
    clear    = clr;
    @(posedge ck);
    #1;
    model_step(ld, sh, v, clr);
    $display("%s ld=%0d sh=%0d clr=%0d val=%0d | max top=%0d cnt=%0d | min top=%0d cnt=%0d",
             ctx, ld, sh, clr, v, top_mx, cnt_mx, top_mn, cnt_mn);
    check_outputs(ctx);
    loadIn   = 1'b0;
    shiftOut = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    r        = 1'b0;
    clear    = 1'b0;
    loadIn   = 1'b0;
    shiftOut = 1'b0;
    newVal   = '0;
    model_reset();
    #12;
    check_outputs("reset");
    r = 1'b1;

    // Basic ordering: 5,9,3 then drain past empty.
    do_op("ins5", 1, 0, 5, 0);
    do_op("ins9", 1, 0, 9, 0);
    do_op("ins3", 1, 0, 3, 0);
    repeat (3) do_op("rem", 0, 1, 0, 0);
    do_op("rem_empty", 0, 1, 0, 0);
    do_op("clear", 0, 0, 0, 1);
    do_op("swap_empty", 1, 1, 42, 0);

    // Fill, overflow, swap while full, then drain to confirm order.
    for (int k = 1; k <= D; k++) do_op("fill", 1, 0, k, 0);
    do_op("ins_full", 1, 0, 200, 0);
    do_op("swap_full", 1, 1, 0, 0);
    repeat (D) do_op("drain", 0, 1, 0, 0);
    do_op("clear", 0, 0, 0, 1);

    // Ties interleaved with a larger key.
    do_op("tie4", 1, 0, 4, 0);
    do_op("tie6", 1, 0, 6, 0);
    do_op("tie4", 1, 0, 4, 0);
    do_op("tie4", 1, 0, 4, 0);
    do_op("tie_rem", 0, 1, 0, 0);
    do_op("clear", 0, 0, 0, 1);

    // Min-first ordering scenario (both instances checked).
    do_op("ins7", 1, 0, 7, 0);
    do_op("ins2", 1, 0, 2, 0);
    do_op("ins5", 1, 0, 5, 0);
    repeat (3) do_op("rem", 0, 1, 0, 0);

    // Randomised traffic with frequent ties.
    for (int n = 0; n < 300; n++) begin
      int sel;
      bit ld, sh, clr;
      sel = $urandom_range(0, 9);
      ld  = (sel < 5) || (sel == 8);
      sh  = (sel >= 5);
      clr = ($urandom_range(0, 39) == 0);
      do_op("rand", ld, sh, $urandom_range(0, 15), clr);
    end

    // Asynchronous reset while full, between clock edges.
    do_op("clear", 0, 0, 0, 1);
    for (int k = 0; k < D; k++) do_op("fill_r", 1, 0, $urandom_range(0, 255), 0);
    #1;
    r = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    r = 1'b1;
    do_op("post_rst_ins", 1, 0, 77, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
